// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-master memory port arbiter: FSM states and master ids.
package arb_def;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RVALID
    } arb_state_t;

    typedef logic master_id_t;

    localparam master_id_t MASTER_INSTR = 1'b0;
    localparam master_id_t MASTER_DATA  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner selection for the two masters.
// MEM_ARB_ROUND_ROBIN_EN: ties go to the master that did not win last; otherwise data wins.
module arb_pick
    import arb_def::*;
(
    input  logic       m0_req,
    input  logic       m1_req,
    input  master_id_t last_winner,
    output logic       valid,
    output master_id_t winner
);

    always_comb begin
        valid  = m0_req | m1_req;
        winner = MASTER_INSTR;
        if (m0_req && m1_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            winner = ~last_winner;
`else
            winner = MASTER_DATA;
`endif
        end else if (m1_req) begin
            winner = MASTER_DATA;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter in front of the data cache port; one transaction outstanding,
// downstream request registered and held until grant. Tie policy set by MEM_ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
    import arb_def::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    m0_req_i,
    output logic                    m0_gnt_o,
    output logic                    m0_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,

    input  logic                    m1_req_i,
    output logic                    m1_gnt_o,
    output logic                    m1_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,

    output logic                    out_req_o,
    output logic [ADDR_WIDTH-1:0]   out_addr_o,
    output logic                    out_we_o,
    output logic [DATA_WIDTH/8-1:0] out_be_o,
    output logic [DATA_WIDTH-1:0]   out_wdata_o,
    input  logic                    out_gnt_i,
    input  logic                    out_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   out_rdata_i
);

    arb_state_t state;
    master_id_t owner;
    master_id_t last_winner;
    logic       pick_valid;
    master_id_t pick_winner;

    logic [1:0]                 gnt_q;
    logic [1:0]                 rvalid_q;
    logic [1:0][DATA_WIDTH-1:0] rdata_q;

    arb_pick u_pick (
        .m0_req      (m0_req_i),
        .m1_req      (m1_req_i),
        .last_winner (last_winner),
        .valid       (pick_valid),
        .winner      (pick_winner)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            owner       <= MASTER_INSTR;
            last_winner <= MASTER_DATA;
            out_req_o   <= 1'b0;
            out_addr_o  <= '0;
            out_we_o    <= 1'b0;
            out_be_o    <= '0;
            out_wdata_o <= '0;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
        end else begin
            // Master-side outputs are single-cycle pulses; rdata is zero outside rvalid.
            gnt_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner       <= pick_winner;
                        out_req_o   <= 1'b1;
                        out_addr_o  <= pick_winner ? m1_addr_i  : m0_addr_i;
                        out_we_o    <= pick_winner ? m1_we_i    : m0_we_i;
                        out_be_o    <= pick_winner ? m1_be_i    : m0_be_i;
                        out_wdata_o <= pick_winner ? m1_wdata_i : m0_wdata_i;
                        state       <= WAIT_GNT;
                    end
                end
                WAIT_GNT: begin
                    if (out_gnt_i) begin
                        out_req_o    <= 1'b0;
                        out_addr_o   <= '0;
                        out_we_o     <= 1'b0;
                        out_be_o     <= '0;
                        out_wdata_o  <= '0;
                        gnt_q[owner] <= 1'b1;
                        last_winner  <= owner;
                        if (out_rvalid_i) begin
                            rvalid_q[owner] <= 1'b1;
                            rdata_q[owner]  <= out_rdata_i;
                            state           <= IDLE;
                        end else begin
                            state <= WAIT_RVALID;
                        end
                    end
                end
                WAIT_RVALID: begin
                    if (out_rvalid_i) begin
                        rvalid_q[owner] <= 1'b1;
                        rdata_q[owner]  <= out_rdata_i;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m0_gnt_o    = gnt_q[0];
    assign m1_gnt_o    = gnt_q[1];
    assign m0_rvalid_o = rvalid_q[0];
    assign m1_rvalid_o = rvalid_q[1];
    assign m0_rdata_o  = rdata_q[0];
    assign m1_rdata_o  = rdata_q[1];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter; a transaction-level model tracks
// pending requests and the last winner to predict every grant, response and downstream request.
module tb_mem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;

    logic [1:0]         req;
    logic [1:0][AW-1:0] addr;
    logic [1:0]         we;
    logic [1:0][BW-1:0] be;
    logic [1:0][DW-1:0] wdata;

    logic          m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
    logic [DW-1:0] m0_rdata_o, m1_rdata_o;
    logic          out_req_o, out_we_o;
    logic [AW-1:0] out_addr_o;
    logic [BW-1:0] out_be_o;
    logic [DW-1:0] out_wdata_o;
    logic          out_gnt_i = 1'b0;
    logic          out_rvalid_i = 1'b0;
    logic [DW-1:0] out_rdata_i = '0;

    int n_chk = 0;
    int n_err = 0;
    bit lw;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .m0_req_i     (req[0]),
        .m0_gnt_o     (m0_gnt_o),
        .m0_rvalid_o  (m0_rvalid_o),
        .m0_addr_i    (addr[0]),
        .m0_we_i      (we[0]),
        .m0_be_i      (be[0]),
        .m0_wdata_i   (wdata[0]),
        .m0_rdata_o   (m0_rdata_o),
        .m1_req_i     (req[1]),
        .m1_gnt_o     (m1_gnt_o),
        .m1_rvalid_o  (m1_rvalid_o),
        .m1_addr_i    (addr[1]),
        .m1_we_i      (we[1]),
        .m1_be_i      (be[1]),
        .m1_wdata_i   (wdata[1]),
        .m1_rdata_o   (m1_rdata_o),
        .out_req_o    (out_req_o),
        .out_addr_o   (out_addr_o),
        .out_we_o     (out_we_o),
        .out_be_o     (out_be_o),
        .out_wdata_o  (out_wdata_o),
        .out_gnt_i    (out_gnt_i),
        .out_rvalid_i (out_rvalid_i),
        .out_rdata_i  (out_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    wire [1:0]         gnt_v = {m1_gnt_o, m0_gnt_o};
    wire [1:0]         rv_v  = {m1_rvalid_o, m0_rvalid_o};
    wire [1:0][DW-1:0] rd_v  = {m1_rdata_o, m0_rdata_o};

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Arbitration rule straight from the policy: single requester wins, ties by policy.
    function automatic bit pick_w(input logic [1:0] r, input bit last);
        if (r == 2'b11) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            return ~last;
`else
            return 1'b1;
`endif
        end
        return r[1];
    endfunction

    function automatic logic [1:0] onehot(input bit w);
        return w ? 2'b10 : 2'b01;
    endfunction

    task automatic raise(input bit m);
        req[m]   = 1'b1;
        addr[m]  = AW'($urandom);
        we[m]    = 1'($urandom);
        be[m]    = BW'($urandom);
        wdata[m] = $urandom;
    endtask

    task automatic chk_req_out(input string tag, input bit w);
        chk({tag, "_req"},   out_req_o,   1'b1);
        chk({tag, "_addr"},  out_addr_o,  addr[w]);
        chk({tag, "_we"},    out_we_o,    we[w]);
        chk({tag, "_be"},    out_be_o,    be[w]);
        chk({tag, "_wdata"}, out_wdata_o, wdata[w]);
    endtask

    task automatic chk_out_clear(input string tag);
        chk({tag, "_out"}, {out_req_o, out_addr_o, out_we_o, out_be_o, out_wdata_o}, '0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_out_clear(tag);
        chk({tag, "_master"}, {gnt_v, rv_v, rd_v}, '0);
    endtask

    // One transaction for master w from an IDLE cycle: gnt after d extra cycles, rvalid
    // either with gnt (same) or r cycles after the gnt-response cycle.
    task automatic serve(input bit w, input int d, input bit same, input int r,
                         input logic [DW-1:0] rd, input bit raise_other);
        @(posedge clk_i); #1;
        chk_req_out("req_lat", w);
        chk("no_early_gnt", {gnt_v, rv_v}, '0);
        repeat (d) begin
            @(posedge clk_i); #1;
            chk_req_out("req_hold", w);
            chk("no_early_gnt", {gnt_v, rv_v}, '0);
        end
        out_gnt_i    = 1'b1;
        out_rvalid_i = same;
        out_rdata_i  = rd;
        @(posedge clk_i); #1;
        out_gnt_i    = 1'b0;
        out_rvalid_i = 1'b0;
        out_rdata_i  = $urandom;
        chk("gnt", gnt_v, onehot(w));
        chk_out_clear("gnt_clear");
        req[w] = 1'b0;
        lw     = w;
        if (same) begin
            chk("rv_same", rv_v, onehot(w));
            chk("rdata_same", rd_v[w], rd);
            chk("rdata_other", rd_v[~w], '0);
        end else begin
            chk("rv_none", {rv_v, rd_v}, '0);
            if (raise_other && !req[~w]) raise(~w);
            repeat (r) begin
                out_gnt_i = 1'($urandom);
                @(posedge clk_i); #1;
                out_gnt_i = 1'b0;
                chk("wait_rv", {gnt_v, rv_v, out_req_o}, '0);
            end
            out_rvalid_i = 1'b1;
            out_rdata_i  = rd;
            @(posedge clk_i); #1;
            out_rvalid_i = 1'b0;
            out_rdata_i  = $urandom;
            chk("rv", {gnt_v, rv_v}, {2'b00, onehot(w)});
            chk("rdata", rd_v[w], rd);
            chk("rdata_other", rd_v[~w], '0);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            out_gnt_i    = 1'($urandom);
            out_rvalid_i = 1'($urandom);
            out_rdata_i  = $urandom;
            @(posedge clk_i); #1;
            out_gnt_i    = 1'b0;
            out_rvalid_i = 1'b0;
            chk_all_zero("idle_spurious");
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 4 && req != 2'b00; k++)
            serve(pick_w(req, lw), $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 2),
                  $urandom, 1'b0);
    endtask

    initial begin
        req = '0; addr = '0; we = '0; be = '0; wdata = '0;
        lw  = 1'b1;
        #12;
        chk_all_zero("reset");
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        // Single read from instruction fetch.
        req[0] = 1'b1; addr[0] = 16'h0040; we[0] = 1'b0; be[0] = 4'hF; wdata[0] = '0;
        serve(1'b0, 2, 1'b0, 0, 32'hDEADBEEF, 1'b0);

        // Simultaneous requests; the winner keeps requesting.
        req = 2'b11;
        addr[0] = 16'h0010; we[0] = 1'b0; be[0] = 4'hF; wdata[0] = '0;
        addr[1] = 16'h0020; we[1] = 1'b1; be[1] = 4'hF; wdata[1] = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            bit w;
            w = pick_w(req, lw);
            serve(w, 1, 1'b0, 0, $urandom, 1'b0);
            req[w] = 1'b1;
        end
        drain();

        // Same-cycle gnt and rvalid, then an immediate follow-on request.
        raise(1'b1);
        serve(1'b1, 0, 1'b1, 0, 32'hA5A5A5A5, 1'b0);
        raise(1'b0);
        serve(1'b0, 0, 1'b0, 0, $urandom, 1'b0);

        // Late request arriving during WAIT_RVALID.
        raise(1'b0);
        serve(1'b0, 1, 1'b0, 2, $urandom, 1'b1);
        drain();

        idle_cycles(4);

        for (int i = 0; i < 60; i++) begin
            if (req == 2'b00) begin
                idle_cycles($urandom_range(0, 2));
                if ($urandom_range(0, 1) == 1) raise(1'b0);
                if ($urandom_range(0, 1) == 1 || req == 2'b00) raise(1'b1);
            end else if (!req[0] && $urandom_range(0, 2) == 0) begin
                raise(1'b0);
            end else if (!req[1] && $urandom_range(0, 2) == 0) begin
                raise(1'b1);
            end
            serve(pick_w(req, lw), $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 2),
                  $urandom, 1'($urandom));
        end
        drain();

        // Reset during WAIT_GNT while a grant is being presented.
        raise(1'b0);
        @(posedge clk_i); #1;
        chk_req_out("pre_reset", 1'b0);
        out_gnt_i = 1'b1;
        #1 rst_ni = 1'b0;
        #1 chk_all_zero("async_reset");
        @(posedge clk_i); #1;
        out_gnt_i = 1'b0;
        chk_all_zero("reset_hold");
        rst_ni = 1'b1;
        lw     = 1'b1;
        serve(1'b0, 1, 1'b0, 1, $urandom, 1'b0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        req = 2'b11;
        serve(pick_w(req, lw), 0, 1'b1, 0, $urandom, 1'b0);
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
